// File: rtl/onehot_dec_pipe.sv
// Registered binary-to-one-hot decoder with valid/ready on both sides.
// Define ONEHOT_DEC_SCAN_EN to build the autonomous scan mode (SCAN_OUT/SCAN_WAIT, dwell counter).
module onehot_dec_pipe #(
    parameter  int IN_W    = 2,
    parameter  int DWELL_W = 4,
    localparam int OUT_W   = 2**IN_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [IN_W-1:0]    in_code,
    input  logic               en,
    input  logic               scan_en,
    input  logic [DWELL_W-1:0] dwell,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [OUT_W-1:0]   out_onehot,
    output logic [IN_W-1:0]    out_code,
    output logic               busy
);

    logic               out_valid_q, out_valid_d;
    logic [IN_W-1:0]    out_code_q, out_code_d;
    logic [OUT_W-1:0]   out_onehot_q, out_onehot_d;

    logic               free;
    logic               load;
    logic               load_hot;
    logic [IN_W-1:0]    load_code;
    logic [IN_W-1:0]    scan_next;
    logic [OUT_W-1:0]   dec_vec;

    assign free      = !out_valid_q || out_ready;
    assign scan_next = out_code_q + IN_W'(1);

    generate
        for (genvar gi = 0; gi < OUT_W; gi++) begin : g_dec
            assign dec_vec[gi] = (load_code == IN_W'(gi));
        end
    endgenerate

`ifdef ONEHOT_DEC_SCAN_EN
    typedef enum logic [1:0] {
        IDLE,
        SCAN_OUT,
        SCAN_WAIT
    } state_t;

    state_t             state_q, state_d;
    logic [DWELL_W-1:0] cnt_q, cnt_d;

    // Gated by rst_n so upstream never sees a handshake while the block is held in reset.
    assign in_ready = rst_n && (state_q == IDLE) && free && !scan_en;
    assign busy     = (state_q != IDLE) || out_valid_q;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        load        = 1'b0;
        load_hot    = 1'b0;
        load_code   = in_code;
        out_valid_d = out_valid_q;
        case (state_q)
            IDLE: begin
                if (scan_en && free) begin
                    load        = 1'b1;
                    load_hot    = 1'b1;
                    load_code   = '0;
                    out_valid_d = 1'b1;
                    state_d     = SCAN_OUT;
                end else if (in_valid && in_ready) begin
                    load        = 1'b1;
                    load_hot    = en;
                    load_code   = in_code;
                    out_valid_d = 1'b1;
                end else if (free) begin
                    out_valid_d = 1'b0;
                end
            end
            SCAN_OUT: begin
                if (out_valid_q && out_ready) begin
                    if (!scan_en) begin
                        out_valid_d = 1'b0;
                        state_d     = IDLE;
                    end else if (dwell == '0) begin
                        load      = 1'b1;
                        load_hot  = 1'b1;
                        load_code = scan_next;
                    end else begin
                        out_valid_d = 1'b0;
                        cnt_d       = dwell;
                        state_d     = SCAN_WAIT;
                    end
                end
            end
            SCAN_WAIT: begin
                if (!scan_en) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end else if (cnt_q == DWELL_W'(1)) begin
                    load        = 1'b1;
                    load_hot    = 1'b1;
                    load_code   = scan_next;
                    out_valid_d = 1'b1;
                    cnt_d       = '0;
                    state_d     = SCAN_OUT;
                end else begin
                    cnt_d = cnt_q - DWELL_W'(1);
                end
            end
            default: begin
                state_d     = IDLE;
                cnt_d       = '0;
                out_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end
`else
    logic unused_scan;
    assign unused_scan = &{1'b0, scan_en, dwell};

    assign in_ready = rst_n && free;
    assign busy     = out_valid_q;

    always_comb begin
        load        = 1'b0;
        load_hot    = 1'b0;
        load_code   = in_code;
        out_valid_d = out_valid_q;
        if (in_valid && in_ready) begin
            load        = 1'b1;
            load_hot    = en;
            out_valid_d = 1'b1;
        end else if (free) begin
            out_valid_d = 1'b0;
        end
    end
`endif

    always_comb begin
        out_code_d   = out_code_q;
        out_onehot_d = out_onehot_q;
        if (load) begin
            out_code_d   = load_code;
            out_onehot_d = load_hot ? dec_vec : '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q  <= 1'b0;
            out_code_q   <= '0;
            out_onehot_q <= '0;
        end else begin
            out_valid_q  <= out_valid_d;
            out_code_q   <= out_code_d;
            out_onehot_q <= out_onehot_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_code   = out_code_q;
    assign out_onehot = out_onehot_q;

endmodule

// File: tb/tb_onehot_dec_pipe.sv
// Directed bench for onehot_dec_pipe (IN_W=2, DWELL_W=4); scan steps are built when ONEHOT_DEC_SCAN_EN is defined.
module tb_onehot_dec_pipe;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [1:0] in_code;
    logic       en;
    logic       scan_en;
    logic [3:0] dwell;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] out_onehot;
    logic [1:0] out_code;
    logic       busy;

    int vectors     = 0;
    int miscompares = 0;

    onehot_dec_pipe #(.IN_W(2), .DWELL_W(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_code    (in_code),
        .en         (en),
        .scan_en    (scan_en),
        .dwell      (dwell),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_onehot (out_onehot),
        .out_code   (out_code),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_beat(input string tag, input logic [1:0] code, input logic [3:0] hot);
        chk({tag, "_valid"}, 32'(out_valid), 32'd1);
        chk({tag, "_code"}, 32'(out_code), 32'(code));
        chk({tag, "_onehot"}, 32'(out_onehot), 32'(hot));
        $display("beat %s: code=%0d onehot=%b", tag, out_code, out_onehot);
    endtask

    logic [1:0] dec_codes [4] = '{2'd3, 2'd2, 2'd1, 2'd0};
    logic [3:0] dec_hots  [4] = '{4'b1000, 4'b0100, 4'b0010, 4'b0001};
`ifdef ONEHOT_DEC_SCAN_EN
    logic [1:0] scan_codes [4] = '{2'd1, 2'd2, 2'd3, 2'd0};
    logic [3:0] scan_hots  [4] = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
    logic [1:0] run_codes  [5] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    logic [3:0] run_hots   [5] = '{4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
`endif

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_code   = 2'd0;
        en        = 1'b1;
        scan_en   = 1'b0;
        dwell     = 4'd0;
        out_ready = 1'b1;
        #2;
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_onehot", 32'(out_onehot), 32'd0);
        chk("rst_code", 32'(out_code), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        #1;
        chk("rel_in_ready", 32'(in_ready), 32'd1);

        // Back-to-back decode 3,2,1,0
        in_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            in_code = dec_codes[k];
            tick();
            chk_beat("dec", dec_codes[k], dec_hots[k]);
        end
        in_valid = 1'b0;
        tick();
        chk("dec_drain_valid", 32'(out_valid), 32'd0);
        chk("dec_drain_busy", 32'(busy), 32'd0);

        // en=0 gives all-zero one-hot
        in_valid = 1'b1;
        in_code  = 2'd2;
        en       = 1'b0;
        tick();
        chk_beat("en0", 2'd2, 4'b0000);
        in_valid = 1'b0;
        en       = 1'b1;
        tick();
        chk("en0_drain_valid", 32'(out_valid), 32'd0);

        // Backpressure
        in_valid = 1'b1;
        in_code  = 2'd1;
        tick();
        chk_beat("bp_acc", 2'd1, 4'b0010);
        out_ready = 1'b0;
        in_code   = 2'd3;
        #1;
        chk("bp_in_ready_low", 32'(in_ready), 32'd0);
        tick();
        chk_beat("bp_hold1", 2'd1, 4'b0010);
        tick();
        chk_beat("bp_hold2", 2'd1, 4'b0010);
        out_ready = 1'b1;
        #1;
        chk("bp_in_ready_high", 32'(in_ready), 32'd1);
        tick();
        chk_beat("bp_next", 2'd3, 4'b1000);
        in_valid = 1'b0;
        tick();
        chk("bp_drain_valid", 32'(out_valid), 32'd0);

        // Reset while a beat is held drops it immediately
        in_valid  = 1'b1;
        in_code   = 2'd3;
        out_ready = 1'b0;
        tick();
        chk_beat("held", 2'd3, 4'b1000);
        in_valid = 1'b0;
        rst_n    = 1'b0;
        #1;
        chk("held_rst_valid", 32'(out_valid), 32'd0);
        chk("held_rst_onehot", 32'(out_onehot), 32'd0);
        chk("held_rst_code", 32'(out_code), 32'd0);
        chk("held_rst_busy", 32'(busy), 32'd0);
        tick();
        rst_n     = 1'b1;
        out_ready = 1'b1;
        #1;
        chk("held_rel_in_ready", 32'(in_ready), 32'd1);

`ifdef ONEHOT_DEC_SCAN_EN
        // Scan with dwell=2; simultaneous in_valid loses to scan_en
        scan_en  = 1'b1;
        dwell    = 4'd2;
        in_valid = 1'b1;
        in_code  = 2'd1;
        #1;
        chk("scan_in_ready", 32'(in_ready), 32'd0);
        tick();
        in_valid = 1'b0;
        chk_beat("scan_entry", 2'd0, 4'b0001);
        chk("scan_busy", 32'(busy), 32'd1);
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("dwell_gap0", 32'(out_valid), 32'd0);
            tick();
            chk("dwell_gap1", 32'(out_valid), 32'd0);
            tick();
            chk_beat("dwell2", scan_codes[k], scan_hots[k]);
        end

        // dwell=0: continuous stream
        dwell = 4'd0;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk_beat("dwell0", run_codes[k], run_hots[k]);
        end
        tick();
        chk_beat("exit_code2", 2'd2, 4'b0100);

        // Exit while code 2 is held
        out_ready = 1'b0;
        scan_en   = 1'b0;
        #1;
        chk("exit_in_ready_low", 32'(in_ready), 32'd0);
        tick();
        chk_beat("exit_hold1", 2'd2, 4'b0100);
        tick();
        chk_beat("exit_hold2", 2'd2, 4'b0100);
        out_ready = 1'b1;
        tick();
        chk("exit_valid", 32'(out_valid), 32'd0);
        chk("exit_in_ready", 32'(in_ready), 32'd1);
        chk("exit_busy", 32'(busy), 32'd0);
        tick();
        chk("exit_no_code3", 32'(out_valid), 32'd0);

        // Reset in SCAN_WAIT, then restart from code 0
        scan_en = 1'b1;
        dwell   = 4'd1;
        tick();
        chk_beat("w_entry", 2'd0, 4'b0001);
        tick();
        chk("w_gap0", 32'(out_valid), 32'd0);
        tick();
        chk_beat("w_beat1", 2'd1, 4'b0010);
        tick();
        chk("w_wait_valid", 32'(out_valid), 32'd0);
        chk("w_wait_busy", 32'(busy), 32'd1);
        chk("w_wait_onehot", 32'(out_onehot), 32'b0010);
        rst_n = 1'b0;
        #1;
        chk("w_rst_busy", 32'(busy), 32'd0);
        chk("w_rst_code", 32'(out_code), 32'd0);
        chk("w_rst_onehot", 32'(out_onehot), 32'd0);
        chk("w_rst_in_ready", 32'(in_ready), 32'd0);
        tick();
        rst_n = 1'b1;
        #1;
        chk("w_rel_in_ready", 32'(in_ready), 32'd0);
        tick();
        chk_beat("w_restart", 2'd0, 4'b0001);
        scan_en = 1'b0;
        tick();
        chk("w_exit_valid", 32'(out_valid), 32'd0);
`else
        // scan_en and dwell are ignored without the scan build
        scan_en  = 1'b1;
        dwell    = 4'd0;
        in_valid = 1'b1;
        in_code  = 2'd2;
        #1;
        chk("noscan_in_ready", 32'(in_ready), 32'd1);
        tick();
        chk_beat("noscan_dec", 2'd2, 4'b0100);
        chk("noscan_busy", 32'(busy), 32'd1);
        in_valid = 1'b0;
        tick();
        chk("noscan_valid", 32'(out_valid), 32'd0);
        chk("noscan_busy_idle", 32'(busy), 32'd0);
        tick();
        chk("noscan_stays_idle", 32'(out_valid), 32'd0);
        scan_en = 1'b0;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
